// File: rtl/xnor_lfsr_noise.sv
// xnor_lfsr_noise: XNOR-feedback LFSR noise generator with rate divider,
// seed load, single-step and recovery from the all-ones lockup state.
module xnor_lfsr_noise #(
  parameter int unsigned      WIDTH     = 17,
  parameter int unsigned      TAP_A     = 17,
  parameter int unsigned      TAP_B     = 14,
  parameter int unsigned      DIV_WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED      = '0
) (
  input  logic                 MasterClock,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic [DIV_WIDTH-1:0] Divider,
  input  logic                 Load,
  input  logic [WIDTH-1:0]     Seed,
  input  logic                 Step,
  output logic [WIDTH-1:0]     State,
  output logic                 NoiseBit,
  output logic                 StepPulse,
  output logic                 Lockup
);

  localparam int unsigned TA_IDX = TAP_A - 1;
  localparam int unsigned TB_IDX = TAP_B - 1;

  logic [WIDTH-1:0]     state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pulse_q, pulse_d;
  logic                 fb;
  logic                 lock;
  logic                 shift;

  // Feedback, lockup detect, shift decision and next-state selection
  always_comb begin
    fb      = ~(state_q[TA_IDX] ^ state_q[TB_IDX]);
    lock    = &state_q;
    shift   = 1'b0;
    cnt_d   = cnt_q;
    state_d = state_q;

    if (Load) begin
      cnt_d   = Divider;
      state_d = Seed;
    end else if (Enable) begin
      if (cnt_q == '0) begin
        shift = 1'b1;
        cnt_d = Divider;
      end else begin
        cnt_d = cnt_q - DIV_WIDTH'(1);
      end
    end else begin
      shift = Step;
    end

    if (shift) begin
      state_d = lock ? '0 : {state_q[WIDTH-2:0], fb};
    end
    pulse_d = shift;
  end

  // State, divider counter and shift-pulse registers
  always_ff @(posedge MasterClock or posedge Reset) begin
    if (Reset) begin
      state_q <= SEED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign State     = state_q;
  assign NoiseBit  = state_q[WIDTH-1];
  assign StepPulse = pulse_q;
  assign Lockup    = lock;

endmodule

// File: tb/tb_xnor_lfsr_noise.sv
// Directed testbench for xnor_lfsr_noise.
module tb_xnor_lfsr_noise;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  div;
  logic        load;
  logic [16:0] seed;
  logic        step;
  logic [16:0] state;
  logic        noise;
  logic        pulse;
  logic        lock;

  // Small 7-bit instance so a full period fits in a short run
  logic        s_rst;
  logic        s_en;
  logic [7:0]  s_div;
  logic        s_load;
  logic [6:0]  s_seed;
  logic        s_step;
  logic [6:0]  s_state;
  logic        s_noise;
  logic        s_pulse;
  logic        s_lock;

  int total = 0;
  int bad   = 0;

  xnor_lfsr_noise dut (
    .MasterClock(clk), .Reset(rst), .Enable(en), .Divider(div),
    .Load(load), .Seed(seed), .Step(step), .State(state),
    .NoiseBit(noise), .StepPulse(pulse), .Lockup(lock)
  );

  xnor_lfsr_noise #(.WIDTH(7), .TAP_A(7), .TAP_B(6), .DIV_WIDTH(8), .SEED(7'h00)) dut_s (
    .MasterClock(clk), .Reset(s_rst), .Enable(s_en), .Divider(s_div),
    .Load(s_load), .Seed(s_seed), .Step(s_step), .State(s_state),
    .NoiseBit(s_noise), .StepPulse(s_pulse), .Lockup(s_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; returns #1 after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int pc;
  int per;
  logic lock_seen;
  logic zero_seen;

  initial begin
    rst = 1'b1; en = 1'b0; div = 8'd0; load = 1'b0; seed = '0; step = 1'b0;
    s_rst = 1'b1; s_en = 1'b0; s_div = 8'd0; s_load = 1'b0; s_seed = '0; s_step = 1'b0;
    tick();

    // Reset values
    check("rst_state", 32'(state), 32'h0);
    check("rst_pulse", 32'(pulse), 32'h0);
    check("rst_lock",  32'(lock),  32'h0);
    check("rst_noise", 32'(noise), 32'h0);

    // Divider = 0 free run: shifts every cycle
    rst = 1'b0; en = 1'b1; div = 8'd0;
    pc = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (pulse) pc++;
      if (i == 1)  check("run_s1",  32'(state), 32'h00001);
      if (i == 2)  check("run_s2",  32'(state), 32'h00003);
      if (i == 3)  check("run_s3",  32'(state), 32'h00007);
      if (i == 14) check("run_s14", 32'(state), 32'h03FFF);
      if (i == 15) check("run_s15", 32'(state), 32'h07FFE);
    end
    check("run_pulses", 32'(pc), 32'd15);
    check("run_noise", 32'(noise), 32'h0);

    // Divider = 3: shifts on enabled cycles 0, 4, 8
    en = 1'b0;
    apply_reset();
    en = 1'b1; div = 8'd3;
    pc = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pulse) pc++;
      if (i == 0) check("div_c0", 32'(state), 32'h00001);
      if (i == 3) check("div_c3", 32'(state), 32'h00001);
      if (i == 4) check("div_c4", 32'(state), 32'h00003);
    end
    en = 1'b0;
    check("div_pulses", 32'(pc), 32'd3);
    check("div_state", 32'(state), 32'h00007);

    // Single step with Enable low
    apply_reset();
    step = 1'b1; tick(); step = 1'b0;
    check("step1_state", 32'(state), 32'h00001);
    check("step1_pulse", 32'(pulse), 32'h1);
    tick();
    check("step_gap_pulse", 32'(pulse), 32'h0);
    check("step_gap_state", 32'(state), 32'h00001);
    tick();
    step = 1'b1; tick(); step = 1'b0;
    check("step2_state", 32'(state), 32'h00003);
    check("step2_pulse", 32'(pulse), 32'h1);
    tick();

    // Step held with Enable = 1, Divider = 5: only divider-paced shifts
    en = 1'b1; div = 8'd5; step = 1'b1;
    pc = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pulse) pc++;
    end
    en = 1'b0; step = 1'b0;
    check("stephold_pulses", 32'(pc), 32'd2);
    check("stephold_state", 32'(state), 32'h0000F);

    // Load all-ones, lockup recovery, Load+Enable gives no shift
    div = 8'd0;
    load = 1'b1; seed = 17'h1FFFF; tick(); load = 1'b0;
    check("ld1_state", 32'(state), 32'h1FFFF);
    check("ld1_lock",  32'(lock),  32'h1);
    check("ld1_noise", 32'(noise), 32'h1);
    check("ld1_pulse", 32'(pulse), 32'h0);
    step = 1'b1; tick(); step = 1'b0;
    check("recov_state", 32'(state), 32'h0);
    check("recov_lock",  32'(lock),  32'h0);
    check("recov_pulse", 32'(pulse), 32'h1);
    en = 1'b1; load = 1'b1; seed = 17'h00005; tick(); load = 1'b0;
    check("ldEn_state", 32'(state), 32'h00005);
    check("ldEn_pulse", 32'(pulse), 32'h0);
    tick();
    check("after_ld_state", 32'(state), 32'h0000B);
    check("after_ld_pulse", 32'(pulse), 32'h1);
    en = 1'b0;

    // Asynchronous reset between edges
    apply_reset();
    en = 1'b1; div = 8'd0;
    tick(); tick(); tick();
    check("pre_arst_state", 32'(state), 32'h00007);
    check("pre_arst_pulse", 32'(pulse), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'h0);
    check("arst_pulse", 32'(pulse), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    check("arst_restart", 32'(state), 32'h00001);

    // 17-bit: long free run never hits lockup nor revisits zero early
    apply_reset();
    en = 1'b1; div = 8'd0;
    lock_seen = 1'b0; zero_seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (lock) lock_seen = 1'b1;
      if (state == '0) zero_seen = 1'b1;
    end
    en = 1'b0;
    check("long_nolock", 32'(lock_seen), 32'h0);
    check("long_nozero", 32'(zero_seen), 32'h0);

    // 7-bit instance: full period back to zero after 127 shifts
    s_rst = 1'b1; tick(); s_rst = 1'b0;
    s_en = 1'b1;
    per = 0; lock_seen = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (s_lock) lock_seen = 1'b1;
      if (s_state == '0 && per == 0) per = i;
      if (per != 0) break;
    end
    s_en = 1'b0;
    check("small_period", 32'(per), 32'd127);
    check("small_nolock", 32'(lock_seen), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
